// File: rtl/dcache_nway_ctrl.sv
// Miss/flush controller for an N-way set-associative write-back data cache:
// victim write-back, block fill, halt-time flush of dirty lines, then the hit-count store.
module dcache_nway_ctrl #(
  parameter int unsigned WAYS         = 2,
  parameter int unsigned SETS         = 8,
  parameter int unsigned WORDS        = 2,
  parameter logic [31:0] HIT_CNT_ADDR = 32'h3100,
  localparam int unsigned IW = $clog2(SETS),
  localparam int unsigned OW = $clog2(WORDS),
  localparam int unsigned WW = (WORDS > 1) ? OW : 1,
  localparam int unsigned KW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned TW = 30 - IW - OW
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               halt,
  input  logic               hit,
  input  logic [IW-1:0]      req_idx,
  input  logic [TW-1:0]      req_tag,
  input  logic [KW-1:0]      victim_way,
  input  logic               victim_dirty,
  input  logic [TW-1:0]      victim_tag,
  input  logic [WAYS-1:0]    fl_dirty,
  input  logic [WAYS*TW-1:0] fl_tag,
  input  logic [31:0]        rd_word,
  input  logic [31:0]        hit_count,
  input  logic               mem_ready,
  output logic               dREN,
  output logic               dWEN,
  output logic [31:0]        daddr,
  output logic [31:0]        dstore,
  output logic [IW-1:0]      cache_idx,
  output logic [KW-1:0]      cache_way,
  output logic [WW-1:0]      cache_woff,
  output logic               load_data,
  output logic               set_valid,
  output logic               write_tag,
  output logic               clear_dirty,
  output logic               disable_hit_counter,
  output logic               flushed,
  output logic [2:0]         dbg_state_o
);

  // Memory handshake: dREN/dWEN stay high with daddr/dstore held stable until
  // mem_ready; a beat completes on the cycle the strobe and mem_ready are both high.
  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_FILL, S_WAIT_HIT, S_FL_SCAN, S_FL_WB, S_HIT_WR, S_HALTED
  } state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] w_q, w_d;
  logic [IW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] lw_q, lw_d;
  logic [TW-1:0] lt_q, lt_d;

  logic          last_word, last_way, last_set, scan_adv;
  logic [TW-1:0] fl_tag_k;

  assign last_word = (w_q == WW'(WORDS - 1));
  assign last_way  = (k_q == KW'(WAYS - 1));
  assign last_set  = (s_q == IW'(SETS - 1));
  assign scan_adv  = ((state_q == S_FL_SCAN) && !fl_dirty[k_q]) ||
                     ((state_q == S_FL_WB) && mem_ready && last_word);

  always_comb begin
    fl_tag_k = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (KW'(i) == k_q) fl_tag_k = fl_tag[i*TW +: TW];
    end
  end

  function automatic logic [31:0] mk_addr(input logic [TW-1:0] tag,
                                          input logic [IW-1:0] idx,
                                          input logic [WW-1:0] w);
    mk_addr = (32'(tag) << (IW + OW + 2)) | (32'(idx) << (OW + 2)) | (32'(w) << 2);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST || !enable) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      lw_q    <= '0;
      lt_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      s_q     <= s_d;
      k_q     <= k_d;
      lw_q    <= lw_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    s_d     = s_q;
    k_d     = k_q;
    lw_d    = lw_q;
    lt_d    = lt_q;
    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_FL_SCAN;
          s_d     = '0;
          k_d     = '0;
          w_d     = '0;
        end else if (!hit) begin
          lw_d    = victim_way;
          lt_d    = victim_tag;
          w_d     = '0;
          state_d = victim_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (mem_ready) begin
          if (last_word) begin
            w_d     = '0;
            state_d = S_FILL;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          if (last_word) begin
            w_d     = '0;
            state_d = S_WAIT_HIT;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end
      S_WAIT_HIT: if (hit) state_d = S_IDLE;
      S_FL_SCAN, S_FL_WB: begin
        // A clean line, or the final beat of a dirty one, steps the scan to the next (set, way).
        if (scan_adv) begin
          w_d = '0;
          if (last_way && last_set) begin
            state_d = S_HIT_WR;
          end else begin
            state_d = S_FL_SCAN;
            k_d     = last_way ? '0 : k_q + 1'b1;
            s_d     = last_way ? s_q + 1'b1 : s_q;
          end
        end else if (state_q == S_FL_SCAN) begin
          state_d = S_FL_WB;
          w_d     = '0;
        end else if (mem_ready) begin
          w_d = w_q + 1'b1;
        end
      end
      S_HIT_WR: if (mem_ready) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dREN                = 1'b0;
    dWEN                = 1'b0;
    daddr               = '0;
    dstore              = '0;
    cache_idx           = '0;
    cache_way           = '0;
    cache_woff          = '0;
    load_data           = 1'b0;
    set_valid           = 1'b0;
    write_tag           = 1'b0;
    clear_dirty         = 1'b0;
    disable_hit_counter = 1'b0;
    flushed             = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cache_idx = req_idx;
        cache_way = victim_way;
      end
      S_WB: begin
        dWEN        = 1'b1;
        daddr       = mk_addr(lt_q, req_idx, w_q);
        dstore      = rd_word;
        cache_idx   = req_idx;
        cache_way   = lw_q;
        cache_woff  = w_q;
        clear_dirty = mem_ready && last_word;
      end
      S_FILL: begin
        dREN       = 1'b1;
        daddr      = mk_addr(req_tag, req_idx, w_q);
        cache_idx  = req_idx;
        cache_way  = lw_q;
        cache_woff = w_q;
        load_data  = mem_ready;
        set_valid  = mem_ready && last_word;
        write_tag  = mem_ready && last_word;
      end
      S_WAIT_HIT: begin
        cache_idx           = req_idx;
        cache_way           = lw_q;
        disable_hit_counter = 1'b1;
      end
      S_FL_SCAN: begin
        cache_idx           = s_q;
        cache_way           = k_q;
        disable_hit_counter = 1'b1;
      end
      S_FL_WB: begin
        dWEN                = 1'b1;
        daddr               = mk_addr(fl_tag_k, s_q, w_q);
        dstore              = rd_word;
        cache_idx           = s_q;
        cache_way           = k_q;
        cache_woff          = w_q;
        clear_dirty         = mem_ready && last_word;
        disable_hit_counter = 1'b1;
      end
      S_HIT_WR: begin
        dWEN                = 1'b1;
        daddr               = HIT_CNT_ADDR;
        dstore              = hit_count;
        disable_hit_counter = 1'b1;
      end
      S_HALTED: begin
        flushed             = 1'b1;
        disable_hit_counter = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// Bench for dcache_nway_ctrl: table-driven misses, hand-written stall/flush/reset
// sequences, random misses and flushes against a transaction-list model, plus a 4/16/4 flush.
module tb_dcache_nway_ctrl;
  localparam int WAYS  = 2;
  localparam int SETS  = 8;
  localparam int WORDS = 2;
  localparam int IW = $clog2(SETS);
  localparam int OW = $clog2(WORDS);
  localparam int WW = (WORDS > 1) ? OW : 1;
  localparam int KW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TW = 30 - IW - OW;
  localparam logic [31:0] HC_ADDR = 32'h3100;
  localparam int W = 69;

  localparam int BWAYS = 4;
  localparam int BSETS = 16;
  localparam int BWORDS = 4;
  localparam int BIW = $clog2(BSETS);
  localparam int BOW = $clog2(BWORDS);
  localparam int BKW = $clog2(BWAYS);
  localparam int BTW = 30 - BIW - BOW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance signals
  logic rst, enable, halt, hit, victim_dirty, mem_ready;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag, victim_tag;
  logic [KW-1:0] victim_way;
  logic [WAYS-1:0] fl_dirty;
  logic [WAYS*TW-1:0] fl_tag;
  logic [31:0] rd_word, hit_count;
  logic dREN, dWEN, load_data, set_valid, write_tag, clear_dirty, disable_hit_counter, flushed;
  logic [31:0] daddr, dstore;
  logic [IW-1:0] cache_idx;
  logic [KW-1:0] cache_way;
  logic [WW-1:0] cache_woff;
  logic [2:0] dbg_state;

  // large instance signals
  logic b_enable, b_halt;
  logic [BWAYS*BTW-1:0] b_fl_tag;
  logic [31:0] b_rd_word, b_hit_count;
  logic b_dREN, b_dWEN, b_load_data, b_set_valid, b_write_tag, b_clear_dirty, b_dhc, b_flushed;
  logic [31:0] b_daddr, b_dstore;
  logic [BIW-1:0] b_cache_idx;
  logic [BKW-1:0] b_cache_way;
  logic [BOW-1:0] b_cache_woff;
  logic [2:0] b_dbg_state;

  dcache_nway_ctrl #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .HIT_CNT_ADDR(HC_ADDR)) u_dut (
    .CLK(clk), .RST(rst), .enable(enable), .halt(halt), .hit(hit),
    .req_idx(req_idx), .req_tag(req_tag), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .fl_dirty(fl_dirty),
    .fl_tag(fl_tag), .rd_word(rd_word), .hit_count(hit_count), .mem_ready(mem_ready),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .cache_idx(cache_idx),
    .cache_way(cache_way), .cache_woff(cache_woff), .load_data(load_data),
    .set_valid(set_valid), .write_tag(write_tag), .clear_dirty(clear_dirty),
    .disable_hit_counter(disable_hit_counter), .flushed(flushed), .dbg_state_o(dbg_state)
  );

  dcache_nway_ctrl #(.WAYS(BWAYS), .SETS(BSETS), .WORDS(BWORDS), .HIT_CNT_ADDR(HC_ADDR)) u_big (
    .CLK(clk), .RST(rst), .enable(b_enable), .halt(b_halt), .hit(1'b1),
    .req_idx('0), .req_tag('0), .victim_way('0), .victim_dirty(1'b0), .victim_tag('0),
    .fl_dirty({BWAYS{1'b1}}), .fl_tag(b_fl_tag), .rd_word(b_rd_word), .hit_count(b_hit_count),
    .mem_ready(1'b1), .dREN(b_dREN), .dWEN(b_dWEN), .daddr(b_daddr), .dstore(b_dstore),
    .cache_idx(b_cache_idx), .cache_way(b_cache_way), .cache_woff(b_cache_woff),
    .load_data(b_load_data), .set_valid(b_set_valid), .write_tag(b_write_tag),
    .clear_dirty(b_clear_dirty), .disable_hit_counter(b_dhc), .flushed(b_flushed),
    .dbg_state_o(b_dbg_state)
  );

  // cache array contents as seen by the controller
  logic dirty_m [SETS][WAYS];
  logic [TW-1:0] tag_m [SETS][WAYS];

  function automatic logic [31:0] rd_fn(input int s, input int k, input int w);
    return 32'h5A00_0000 ^ (32'(s) << 16) ^ (32'(k) << 8) ^ 32'(w);
  endfunction

  function automatic logic [31:0] blk_addr(input logic [31:0] tag, input int idx, input int w);
    return tag * (32'd1 << (IW + OW + 2)) + 32'(idx) * (32'd1 << (OW + 2)) + 32'(w) * 32'd4;
  endfunction

  function automatic logic [W-1:0] pack(input logic we, input logic [31:0] a, input logic [31:0] d,
                                        input logic ld, input logic sv, input logic wt, input logic cd);
    return {we, a, d, ld, sv, wt, cd};
  endfunction

  always_comb begin
    fl_dirty = '0;
    fl_tag   = '0;
    for (int k = 0; k < WAYS; k++) begin
      fl_dirty[k]          = dirty_m[cache_idx][k];
      fl_tag[k*TW +: TW]   = tag_m[cache_idx][k];
    end
  end

  always_comb rd_word = rd_fn(int'(cache_idx), int'(cache_way), int'(cache_woff));

  always_comb begin
    b_fl_tag = '0;
    for (int k = 0; k < BWAYS; k++)
      b_fl_tag[k*BTW +: BTW] = BTW'(32'h100 + 32'(b_cache_idx) * 4 + 32'(k));
  end

  always_comb b_rd_word = 32'hB000_0000 | (32'(b_cache_idx) << 4) | (32'(b_cache_way) << 2) | 32'(b_cache_woff);

  // scoreboard
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  bit b_mon_en = 1'b0;
  int beats, b_beats;
  logic [31:0] first_addr;
  logic first_we;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock: check completed beats at the falling edge, return 1 after the rising edge.
  task automatic tick();
    logic [W-1:0] got, exp;
    int n, s, k, w;
    logic [31:0] ea, ed;
    @(negedge clk);
    if (mon_en && (dREN || dWEN) && mem_ready) begin
      got = pack(dWEN, daddr, dWEN ? dstore : 32'h0, load_data, set_valid, write_tag, clear_dirty);
      if (beats == 0) begin
        first_addr = daddr;
        first_we   = dWEN;
      end
      beats++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_extra got=%h exp=none", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL beat got=%h exp=%h", got, exp);
        end
      end
    end
    if (b_mon_en && b_dWEN) begin
      n = b_beats;
      if (n < BSETS * BWAYS * BWORDS) begin
        s  = n / (BWAYS * BWORDS);
        k  = (n / BWORDS) % BWAYS;
        w  = n % BWORDS;
        ea = 32'((32'h100 + s * 4 + k) * 256 + s * 16 + w * 4);
        ed = 32'hB000_0000 | 32'(s << 4) | 32'(k << 2) | 32'(w);
      end else begin
        ea = HC_ADDR;
        ed = b_hit_count;
      end
      chk("big_addr", b_daddr, ea);
      chk("big_data", b_dstore, ed);
      b_beats++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input int idx, input logic [TW-1:0] tag, input int vway, input bit vdirty,
                         input logic [TW-1:0] vtag, input int stall_n, input bit rnd_ready,
                         output int cycles);
    if (vdirty)
      for (int w = 0; w < WORDS; w++)
        exp_q.push_back(pack(1'b1, blk_addr(32'(vtag), idx, w), rd_fn(idx, vway, w),
                             1'b0, 1'b0, 1'b0, w == WORDS - 1));
    for (int w = 0; w < WORDS; w++)
      exp_q.push_back(pack(1'b0, blk_addr(32'(tag), idx, w), 32'h0,
                           1'b1, w == WORDS - 1, w == WORDS - 1, 1'b0));
    req_idx = IW'(idx); req_tag = tag; victim_way = KW'(vway);
    victim_dirty = vdirty; victim_tag = vtag; halt = 1'b0; hit = 1'b0;
    mem_ready = (stall_n > 0) ? 1'b0 : 1'b1;
    beats = 0; mon_en = 1'b1;
    tick();
    cycles = 1;
    for (int i = 0; i < stall_n; i++) begin
      tick();
      cycles++;
      chk("stall_addr", daddr, blk_addr(32'(vtag), idx, 0));
      chk("stall_data", dstore, rd_fn(idx, vway, 0));
      chk("stall_wen", 32'(dWEN), 32'd1);
    end
    while (!(disable_hit_counter && !dREN && !dWEN) && cycles < 200) begin
      mem_ready    = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      victim_way   = KW'($urandom_range(0, WAYS - 1));
      victim_tag   = TW'($urandom);
      victim_dirty = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    chk("miss_timeout", 32'(cycles < 200), 32'd1);
    chk("miss_q_left", 32'(exp_q.size()), 32'd0);
    hit = 1'b1;
    tick();
    chk("idle_after_hit", {29'd0, dREN, dWEN, disable_hit_counter}, 32'd0);
    exp_q.delete();
    mon_en = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic do_flush(input bit rnd_ready);
    int cycles;
    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS; k++)
        if (dirty_m[s][k])
          for (int w = 0; w < WORDS; w++)
            exp_q.push_back(pack(1'b1, blk_addr(32'(tag_m[s][k]), s, w), rd_fn(s, k, w),
                                 1'b0, 1'b0, 1'b0, w == WORDS - 1));
    exp_q.push_back(pack(1'b1, HC_ADDR, hit_count, 1'b0, 1'b0, 1'b0, 1'b0));
    halt = 1'b1; hit = 1'($urandom_range(0, 1)); victim_dirty = 1'b1;
    mem_ready = 1'b1; beats = 0; mon_en = 1'b1;
    tick();
    halt = 1'($urandom_range(0, 1));
    cycles = 1;
    while (!flushed && cycles < 2000) begin
      mem_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      cycles++;
    end
    chk("flush_timeout", 32'(cycles < 2000), 32'd1);
    chk("flush_q_left", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      chk("halted_hold", {29'd0, flushed, dREN, dWEN}, 32'd4);
    end
    halt = 1'b0; hit = 1'b1; enable = 1'b0;
    tick();
    chk("disable_idle", {29'd0, flushed, disable_hit_counter, dWEN}, 32'd0);
    enable = 1'b1;
    tick();
    chk("reenable_idle", {30'd0, flushed, disable_hit_counter}, 32'd0);
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  task automatic clear_cache();
    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS; k++) begin
        dirty_m[s][k] = 1'b0;
        tag_m[s][k]   = TW'(s * 16 + k + 1);
      end
  endtask

  typedef struct {
    int idx;
    logic [TW-1:0] tag;
    int vway;
    bit vdirty;
    logic [TW-1:0] vtag;
    logic [31:0] exp_addr;
    bit exp_we;
    int exp_beats;
    int exp_cycles;
  } vec_t;

  vec_t vecs [5];
  int cyc;

  initial begin
    vecs[0] = '{3, TW'(32'h1A), 0, 1'b0, TW'(32'h11), 32'h0000_0698, 1'b0, 2, 3};
    vecs[1] = '{2, TW'(32'h33), 1, 1'b1, TW'(32'h05), 32'h0000_0150, 1'b1, 4, 5};
    vecs[2] = '{7, TW'(32'h3FF_FFFF), 1, 1'b0, TW'(32'h0), 32'hFFFF_FFF8, 1'b0, 2, 3};
    vecs[3] = '{0, TW'(32'h2), 0, 1'b1, TW'(32'h0), 32'h0000_0000, 1'b1, 4, 5};
    vecs[4] = '{5, TW'(32'h123), 1, 1'b1, TW'(32'h2AA_AAAA), 32'hAAAA_AAA8, 1'b1, 4, 5};

    rst = 1'b1; enable = 1'b1; halt = 1'b0; hit = 1'b1; mem_ready = 1'b1;
    req_idx = IW'(5); req_tag = '0; victim_way = KW'(1); victim_dirty = 1'b0; victim_tag = '0;
    hit_count = $urandom; b_enable = 1'b1; b_halt = 1'b0; b_hit_count = $urandom;
    clear_cache();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_strobes", {24'd0, dREN, dWEN, load_data, set_valid, write_tag, clear_dirty,
                        disable_hit_counter, flushed}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_idx", 32'(cache_idx), 32'd5);
    chk("rst_way", 32'(cache_way), 32'd1);

    for (int i = 0; i < 5; i++) begin
      do_miss(vecs[i].idx, vecs[i].tag, vecs[i].vway, vecs[i].vdirty, vecs[i].vtag, 0, 1'b0, cyc);
      chk("vec_first_addr", first_addr, vecs[i].exp_addr);
      chk("vec_first_we", 32'(first_we), 32'(vecs[i].exp_we));
      chk("vec_beats", 32'(beats), 32'(vecs[i].exp_beats));
      chk("vec_latency", 32'(cyc), 32'(vecs[i].exp_cycles));
    end

    do_miss(2, TW'(32'h33), 1, 1'b1, TW'(32'h05), 5, 1'b0, cyc);
    chk("stall_latency", 32'(cyc), 32'(2 * WORDS + 1 + 5));

    clear_cache();
    dirty_m[3][1] = 1'b1;
    tag_m[3][1] = TW'(32'h7);
    do_flush(1'b0);
    chk("flush_one_first", first_addr, 32'h0000_01D8);
    chk("flush_one_beats", 32'(beats), 32'd3);

    for (int s = 0; s < SETS; s++)
      for (int k = 0; k < WAYS; k++) dirty_m[s][k] = 1'b1;
    halt = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_fl_wb", {30'd0, dWEN, disable_hit_counter}, 32'd3);
    rst = 1'b1; halt = 1'b0; req_idx = '0; victim_way = '0;
    tick();
    chk("rst_mid_strobes", {24'd0, dREN, dWEN, load_data, set_valid, write_tag, clear_dirty,
                            disable_hit_counter, flushed}, 32'd0);
    chk("rst_mid_bus", daddr | dstore | 32'(cache_idx) | 32'(cache_way) | 32'(cache_woff), 32'd0);
    rst = 1'b0;
    clear_cache();
    dirty_m[0][0] = 1'b1;
    do_flush(1'b0);
    chk("restart_first", first_addr, blk_addr(32'(tag_m[0][0]), 0, 0));

    for (int i = 0; i < 40; i++) begin
      do_miss($urandom_range(0, SETS - 1), TW'($urandom), $urandom_range(0, WAYS - 1),
              1'($urandom_range(0, 1)), TW'($urandom), 0, 1'b1, cyc);
    end

    for (int r = 0; r < 2; r++) begin
      for (int s = 0; s < SETS; s++)
        for (int k = 0; k < WAYS; k++) begin
          dirty_m[s][k] = ($urandom_range(0, 2) == 0);
          tag_m[s][k]   = TW'($urandom);
        end
      hit_count = $urandom;
      do_flush(1'b1);
    end

    b_beats = 0; b_mon_en = 1'b1; b_halt = 1'b1;
    cyc = 0;
    while (!b_flushed && cyc < 1000) begin
      tick();
      cyc++;
    end
    b_halt = 1'b0;
    chk("big_timeout", 32'(cyc < 1000), 32'd1);
    chk("big_beats", 32'(b_beats), 32'(BSETS * BWAYS * BWORDS + 1));
    tick();
    chk("big_flushed_hold", {31'd0, b_flushed}, 32'd1);
    b_mon_en = 1'b0;
    b_enable = 1'b0;
    tick();
    chk("big_disable_idle", {29'd0, b_flushed, b_dhc, b_dWEN}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
